gcd_job_arbiter: RTL and testbench
==================================

# gcd_job_arbiter

Round-robin scheduler that shares one 64-bit sequential GCD engine among NREQ requesters. Each requester hands over an operand pair with a valid/ready transfer and later receives a one-cycle result pulse. The block sits between the Avalon-facing request ports and the engine. It owns engine sequencing (start, wait, optional abort) and resolves zero operands locally, because the engine never terminates on a zero operand.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- TIMEOUT_CYCLES, 1048576, engine cycles allowed per job before abort (used only with GCD_ARB_TIMEOUT_EN)

Ports:
- csi_clk  in  1  sole clock
- rsi_reset_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  requester i has a job pending
- req_a  in  64*NREQ  operand a; requester i at [64*i+63:64*i]
- req_b  in  64*NREQ  operand b; same packing
- req_ready  out  NREQ  one-hot; transfer occurs when req_valid[i] && req_ready[i]
- rsp_valid  out  NREQ  one-hot, one-cycle result pulse to the job owner
- rsp_result  out  64  GCD result; valid while rsp_valid is high, held until next RESP
- rsp_error  out  1  qualifies rsp_valid; 1 = job aborted by timeout
- eng_start  out  1  one-cycle start pulse to the engine
- eng_a, eng_b  out  64 each  engine operands; stable from ISSUE through WAIT
- eng_done  in  1  engine result valid (single-cycle pulse)
- eng_result  in  64  engine result
- eng_abort  out  1  one-cycle synchronous clear to the engine (timeout only)
- busy  out  1  high in any state other than IDLE
- owner  out  $clog2(NREQ)  index of current or most recent job owner

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first i with req_valid[i], searching from ptr+1 modulo NREQ.
  - req_ready[winner] is combinational from req_valid and the registered ptr. It is asserted only in IDLE.
  - On transfer: latch operands, set owner = ptr = winner.
  - If a==0 or b==0: latch result = a|b (0 when both are zero), go to RESP.
  - Otherwise go to ISSUE.
- ISSUE: eng_start=1 for exactly one cycle, then WAIT.
- WAIT:
  - On eng_done, register eng_result, go to RESP.
  - eng_done is ignored in every other state.
- RESP: rsp_valid[owner]=1 for one cycle with rsp_result and rsp_error, then IDLE.
- req_valid is not sticky. Deasserting it before acceptance withdraws the request with no side effects.
- At most one job is in flight. Other requesters see req_ready low until the block returns to IDLE.
- Reset values: all outputs 0, state IDLE, ptr = NREQ-1 (requester 0 has first priority), internal operand/result registers 0.
- Reset mid-job: the job is dropped silently with no rsp_valid. The engine must share rsi_reset_n.

## Timing
- Transfer in cycle T at IDLE.
- Engine path:
  - eng_start at T+1.
  - eng_done observed at cycle D (D ≥ T+2).
  - rsp_valid at D+1.
  - req_ready possible again at D+2.
- Zero-operand path: rsp_valid at T+1, next transfer possible at T+2. Minimum accept interval is 2 cycles.
- eng_a/eng_b change only on a transfer cycle.

## Configuration
- GCD_ARB_TIMEOUT_EN defined:
  - A 32-bit counter clears on entering WAIT and increments each WAIT cycle.
  - When the count reaches TIMEOUT_CYCLES-1 without eng_done, the block pulses eng_abort, goes to RESP with rsp_error=1 and rsp_result=0.
  - If eng_done and the timeout coincide, eng_done wins (error=0).
- GCD_ARB_TIMEOUT_EN undefined:
  - No counter exists. WAIT lasts until eng_done.
  - eng_abort and rsp_error are tied to 0.

## Test plan
- Reset, then requester 2 submits a=48, b=18 -> req_ready=0b0100 in the same cycle, eng_start next cycle, rsp_valid=0b0100 with rsp_result=6 one cycle after eng_done; busy low afterwards.
- All four requesters valid continuously with distinct pairs (e.g. 12/8, 35/21, 81/27, 17/5) -> grants in order 0,1,2,3,0; results 4, 7, 27, 1 routed to the matching rsp_valid bit.
- Requester 1 submits a=0, b=40 -> rsp_result=40 at T+1, eng_start never asserted. Requester 1 submits a=0, b=0 -> rsp_result=0.
- Assert rsi_reset_n low during WAIT for a job from requester 3 -> all outputs 0 immediately, no rsp_valid; after release, requester 0 wins a simultaneous 0/3 request.
- With GCD_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, engine model never asserts eng_done -> eng_abort and rsp_error=1, rsp_result=0 at the 16th WAIT cycle; without the macro, busy stays high indefinitely.

Source files
------------

// File: rtl/gcd_job_arbiter.sv
// Round-robin front end sharing one sequential 64-bit GCD engine among NREQ requesters.
// Optional engine watchdog/abort enabled by defining GCD_ARB_TIMEOUT_EN.

module gcd_job_arbiter_lane (
    input  logic        grant,
    input  logic        rsp_sel,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        ready,
    output logic        rsp,
    output logic [63:0] a_sel,
    output logic [63:0] b_sel
);
    // Masked operands are OR-reduced in the parent, forming a one-hot AND-OR mux.
    assign ready = grant;
    assign rsp   = rsp_sel;
    assign a_sel = a & {64{grant}};
    assign b_sel = b & {64{grant}};
endmodule

module gcd_job_arbiter #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                    csi_clk,
    input  logic                    rsi_reset_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [64*NREQ-1:0]      req_a,
    input  logic [64*NREQ-1:0]      req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [63:0]             rsp_result,
    output logic                    rsp_error,
    output logic                    eng_start,
    output logic [63:0]             eng_a,
    output logic [63:0]             eng_b,
    input  logic                    eng_done,
    input  logic [63:0]             eng_result,
    output logic                    eng_abort,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner
);
    localparam int PW = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("gcd_job_arbiter: NREQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    logic [1:0]                 state;
    logic [PW-1:0]              ptr;
    logic [PW-1:0]              owner_q;
    logic [PW-1:0]              win_idx;
    logic [PW-1:0]              cand;
    logic                       win_found;
    logic [NREQ-1:0]            grant_oh;
    logic [NREQ-1:0]            rsp_oh;
    logic [NREQ-1:0][63:0]      a_lane;
    logic [NREQ-1:0][63:0]      b_lane;
    logic [63:0]                a_mux;
    logic [63:0]                b_mux;
    logic [63:0]                op_a;
    logic [63:0]                op_b;
    logic [63:0]                res_q;
    logic                       xfer;
    logic                       zero_op;
    logic                       tmo_hit;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PW'((int'(ptr) + k) % NREQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Reset gating keeps req_ready low while held in reset even if requests are up.
    assign grant_oh = (rsi_reset_n && state == S_IDLE && win_found) ? (ONE << win_idx) : '0;
    assign rsp_oh   = (state == S_RESP) ? (ONE << owner_q) : '0;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        gcd_job_arbiter_lane u_lane (
            .grant   (grant_oh[i]),
            .rsp_sel (rsp_oh[i]),
            .a       (req_a[64*i +: 64]),
            .b       (req_b[64*i +: 64]),
            .ready   (req_ready[i]),
            .rsp     (rsp_valid[i]),
            .a_sel   (a_lane[i]),
            .b_sel   (b_lane[i])
        );
    end

    always_comb begin
        a_mux = '0;
        b_mux = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_mux = a_mux | a_lane[i];
            b_mux = b_mux | b_lane[i];
        end
    end

    assign xfer    = |grant_oh;
    // The engine never terminates on a zero operand, so those jobs resolve here.
    assign zero_op = (a_mux == 64'd0) || (b_mux == 64'd0);

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            state   <= S_IDLE;
            ptr     <= PW'(NREQ - 1);
            owner_q <= '0;
            op_a    <= '0;
            op_b    <= '0;
            res_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (xfer) begin
                        op_a    <= a_mux;
                        op_b    <= b_mux;
                        owner_q <= win_idx;
                        ptr     <= win_idx;
                        if (zero_op) begin
                            res_q <= a_mux | b_mux;
                            state <= S_RESP;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    if (eng_done) begin
                        res_q <= eng_result;
                        state <= S_RESP;
                    end else if (tmo_hit) begin
                        res_q <= '0;
                        state <= S_RESP;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef GCD_ARB_TIMEOUT_EN
    logic [31:0] tmo_cnt;
    logic        err_q;

    assign tmo_hit = (state == S_WAIT) && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == S_ISSUE)
                tmo_cnt <= '0;
            else if (state == S_WAIT)
                tmo_cnt <= tmo_cnt + 32'd1;
            // A done pulse coinciding with the timeout still counts as success.
            if (state == S_WAIT && (eng_done || tmo_hit))
                err_q <= !eng_done;
            else if (xfer)
                err_q <= 1'b0;
        end
    end

    assign eng_abort = tmo_hit && !eng_done;
    assign rsp_error = (state == S_RESP) && err_q;
`else
    assign tmo_hit   = 1'b0;
    assign eng_abort = 1'b0;
    assign rsp_error = 1'b0;
`endif

    assign eng_start  = (state == S_ISSUE);
    assign busy       = (state != S_IDLE);
    assign eng_a      = op_a;
    assign eng_b      = op_b;
    assign owner      = owner_q;
    assign rsp_result = res_q;

endmodule

// File: tb/tb_gcd_job_arbiter.sv
// Scoreboard bench for gcd_job_arbiter: random requesters, behavioural engine,
// reference arbitration/GCD model in the monitor.

module tb_gcd_job_arbiter;
    localparam int NREQ = 4;
    localparam int TMO  = 16;

    logic                  csi_clk;
    logic                  rsi_reset_n;
    logic [NREQ-1:0]       req_valid;
    logic [64*NREQ-1:0]    req_a;
    logic [64*NREQ-1:0]    req_b;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [63:0]           rsp_result;
    logic                  rsp_error;
    logic                  eng_start;
    logic [63:0]           eng_a;
    logic [63:0]           eng_b;
    logic                  eng_done;
    logic [63:0]           eng_result;
    logic                  eng_abort;
    logic                  busy;
    logic [1:0]            owner;

    gcd_job_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(TMO)) dut (
        .csi_clk     (csi_clk),
        .rsi_reset_n (rsi_reset_n),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_result  (rsp_result),
        .rsp_error   (rsp_error),
        .eng_start   (eng_start),
        .eng_a       (eng_a),
        .eng_b       (eng_b),
        .eng_done    (eng_done),
        .eng_result  (eng_result),
        .eng_abort   (eng_abort),
        .busy        (busy),
        .owner       (owner)
    );

    initial begin
        csi_clk = 1'b0;
        forever #5 csi_clk = ~csi_clk;
    end

    typedef struct {
        int          idx;
        logic [63:0] res;
        logic        err;
    } exp_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sbq[$];
    int          grant_log[$];
    bit          inflight = 0;
    bit          cur_zero = 0;
    bit          cur_hang = 0;
    int          tx_cyc = 0;
    int          done_cyc = -100;
    int          cyc = 0;
    int          mptr = NREQ - 1;
    logic [63:0] last_a = '0;
    logic [63:0] last_b = '0;
    bit          hang = 0;
    int          force_lat = 0;
    logic [NREQ-1:0] last_acc;

    function automatic logic [63:0] gcd64(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Engine model: fixed or random latency, drops the job on reset or abort.
    initial begin
        logic [63:0] ea, eb;
        int lat;
        bit aborted;
        eng_done = 1'b0;
        eng_result = '0;
        forever begin
            @(posedge csi_clk);
            if (rsi_reset_n && eng_start) begin
                ea = eng_a;
                eb = eng_b;
                aborted = 0;
                if (hang) begin
                    while (rsi_reset_n && !eng_abort) @(posedge csi_clk);
                    aborted = 1;
                end else begin
                    lat = (force_lat > 0) ? force_lat : $urandom_range(1, 6);
                    for (int k = 1; k < lat; k++) begin
                        @(posedge csi_clk);
                        if (!rsi_reset_n) begin
                            aborted = 1;
                            break;
                        end
                    end
                end
                if (!aborted && rsi_reset_n) begin
                    #1;
                    eng_done = 1'b1;
                    eng_result = gcd64(ea, eb);
                    @(posedge csi_clk);
                    #1;
                    eng_done = 1'b0;
                    eng_result = 64'hdead_beef_0bad_f00d;
                end
            end
        end
    end

    // Monitor/reference model, sampled mid-cycle.
    initial begin
        logic [NREQ-1:0] exp_rdy;
        logic [63:0] ta, tb;
        bit found;
        int j, exp_rc;
        exp_t e;
        forever begin
            @(negedge csi_clk);
            cyc++;
            if (!rsi_reset_n) begin
                chk("reset_ctrl", {req_ready, rsp_valid, eng_start, eng_abort, busy, owner, rsp_error}, '0);
                chk("reset_result", rsp_result, '0);
                chk("reset_eng_a", eng_a, '0);
                chk("reset_eng_b", eng_b, '0);
                sbq.delete();
                inflight = 0;
                mptr = NREQ - 1;
                last_a = '0;
                last_b = '0;
                done_cyc = -100;
                continue;
            end
            exp_rdy = '0;
            found = 0;
            if (!inflight) begin
                for (int k = 1; k <= NREQ; k++) begin
                    j = (mptr + k) % NREQ;
                    if (!found && req_valid[j]) begin
                        exp_rdy[j] = 1'b1;
                        found = 1;
                    end
                end
            end
            chk("req_ready", req_ready, exp_rdy);
            chk("busy", busy, inflight);
            chk("eng_a_hold", eng_a, last_a);
            chk("eng_b_hold", eng_b, last_b);
            chk("eng_start", eng_start, inflight && !cur_zero && cyc == tx_cyc + 1);
`ifdef GCD_ARB_TIMEOUT_EN
            chk("eng_abort", eng_abort, inflight && cur_hang && cyc == tx_cyc + TMO + 1);
`else
            chk("eng_abort", eng_abort, 1'b0);
`endif
            if (eng_done && inflight) done_cyc = cyc;
            if (rsp_valid != '0) begin
                if (sbq.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, '0);
                end else begin
                    e = sbq.pop_front();
                    exp_rc = cur_zero ? tx_cyc + 1 : (cur_hang ? tx_cyc + TMO + 2 : done_cyc + 1);
                    chk("rsp_valid", rsp_valid, NREQ'(1) << e.idx);
                    chk("rsp_result", rsp_result, e.res);
                    chk("rsp_error", rsp_error, e.err);
                    chk("owner", owner, e.idx);
                    chk("rsp_cycle", cyc, exp_rc);
                end
                inflight = 0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i] && !inflight) begin
                    ta = req_a[64*i +: 64];
                    tb = req_b[64*i +: 64];
                    e.idx = i;
                    e.err = hang;
                    e.res = hang ? 64'd0 : gcd64(ta, tb);
                    sbq.push_back(e);
                    grant_log.push_back(i);
                    mptr = i;
                    last_a = ta;
                    last_b = tb;
                    inflight = 1;
                    cur_zero = (ta == 0) || (tb == 0);
                    cur_hang = hang && !cur_zero;
                    tx_cyc = cyc;
                    done_cyc = -100;
                end
            end
        end
    end

    task automatic step();
        logic [NREQ-1:0] acc;
        @(negedge csi_clk);
        acc = req_valid & req_ready;
        @(posedge csi_clk);
        #1;
        req_valid = req_valid & ~acc;
        last_acc = acc;
    endtask

    task automatic submit(input int i, input logic [63:0] a, input logic [63:0] b);
        req_a[64*i +: 64] = a;
        req_b[64*i +: 64] = b;
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((req_valid != '0 || inflight || sbq.size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk("idle_reached", {63'd0, (req_valid == '0 && !inflight && sbq.size() == 0)}, 64'd1);
    endtask

    task automatic do_reset();
        rsi_reset_n = 1'b0;
        step();
        step();
        rsi_reset_n = 1'b1;
    endtask

    function automatic logic [63:0] rand_op();
        case ($urandom_range(0, 4))
            0: return 64'd0;
            1: return 64'($urandom_range(1, 200));
            2: return {$urandom, $urandom};
            3: return 64'($urandom_range(1, 50)) * 64'd1_000_003;
            default: return 64'($urandom_range(1, 4000)) * 64'd36;
        endcase
    endfunction

    initial begin
        int base, n;
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        rsi_reset_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        last_acc = '0;
        step();
        step();
        rsi_reset_n = 1'b1;

        // Single engine job from requester 2.
        submit(2, 64'd48, 64'd18);
        wait_idle(50);

        // Fair rotation with everyone asking continuously.
        do_reset();
        base = grant_log.size();
        submit(0, 64'd12, 64'd8);
        submit(1, 64'd35, 64'd21);
        submit(2, 64'd81, 64'd27);
        submit(3, 64'd17, 64'd5);
        n = 0;
        while (grant_log.size() < base + 5 && n < 200) begin
            step();
            if (last_acc[0] && grant_log.size() < base + 5) submit(0, 64'd12, 64'd8);
            n++;
        end
        wait_idle(50);
        chk("grant_count", grant_log.size() - base, 5);
        for (int k = 0; k < 5 && base + k < grant_log.size(); k++)
            chk("grant_order", grant_log[base + k], exp_order[k]);

        // Zero-operand jobs bypass the engine.
        submit(1, 64'd0, 64'd40);
        wait_idle(20);
        submit(1, 64'd0, 64'd0);
        wait_idle(20);

        // Reset during WAIT drops the job; requester 0 then has priority.
        force_lat = 30;
        submit(3, 64'd1000, 64'd250);
        step();
        step();
        step();
        rsi_reset_n = 1'b0;
        submit(0, 64'd30, 64'd12);
        submit(3, 64'd14, 64'd21);
        #1;
        chk("async_reset_ctrl", {req_ready, rsp_valid, eng_start, busy, owner}, '0);
        chk("async_reset_eng_a", eng_a, '0);
        step();
        step();
        force_lat = 0;
        rsi_reset_n = 1'b1;
        base = grant_log.size();
        step();
        chk("post_reset_winner", (grant_log.size() > base) ? grant_log[base] : -1, 0);
        wait_idle(60);

        // Engine that never finishes.
        hang = 1;
        submit(2, 64'd99, 64'd33);
`ifdef GCD_ARB_TIMEOUT_EN
        wait_idle(60);
        hang = 0;
`else
        repeat (60) step();
        chk("busy_hang", busy, 1'b1);
        hang = 0;
        do_reset();
`endif

        // Random traffic with withdrawals.
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) submit(i, rand_op(), rand_op());
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        wait_idle(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
